// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller: PC-source encodings,
// MD-unit FSM states and the exception vector.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_SEL_SEQ = 2'b00,
      PC_SEL_EXC = 2'b01,
      PC_SEL_EPC = 2'b10
   } pc_sel_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_MULT = 2'b01,
      MD_DIV  = 2'b10
   } md_state_t;

   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   // Next-PC mux shared with the fetch stage, keyed by the pc_sel code.
   function automatic logic [31:0] next_pc(input logic [1:0] sel,
                                           input logic [31:0] seq_pc,
                                           input logic [31:0] epc);
      logic [31:0] pc;
      pc = seq_pc;
      if (sel == PC_SEL_EXC) pc = EXC_VECTOR;
      else if (sel == PC_SEL_EPC) pc = epc;
      return pc;
   endfunction

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Busy timer for the multiply/divide unit: tracks which operation is in
// flight and counts down its fixed latency.
module md_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic md_go,
   input  logic md_div,
   output logic md_busy
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   md_state_t  state;
   logic [3:0] cnt;

   // A new start always wins, so back-to-back md instructions restart the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else if (md_go) begin
         if (md_div) begin
            state <= MD_DIV;
            cnt   <= DIV_LOAD;
         end else begin
            state <= MD_MULT;
            cnt   <= MULT_LOAD;
         end
         md_busy <= 1'b1;
      end else if (state != MD_IDLE) begin
         if (cnt <= 4'd1) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: stalls for load-use and MD-unit hazards,
// redirects the PC on exceptions and eret, and launches the MD timer.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall_req_D,
   input  logic       md_use_D,
   input  logic       md_start_E,
   input  logic       md_div_E,
   input  logic       exc_M,
   input  logic       eret_M,
   output logic       en_PC,
   output logic       en_FD,
   output logic       flush_FD,
   output logic       flush_DE,
   output logic       flush_EM,
   output logic       flush_MW,
   output logic [1:0] pc_sel,
   output logic       md_go,
   output logic       md_busy
);

   logic stall;

   // A start is dropped when the M stage redirects; the E-stage instruction is being killed.
   assign md_go = md_start_E & ~exc_M & ~eret_M & ~reset;
   assign stall = stall_req_D | (md_use_D & (md_busy | md_start_E));

   md_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_timer (
      .clk     (clk),
      .reset   (reset),
      .md_go   (md_go),
      .md_div  (md_div_E),
      .md_busy (md_busy)
   );

   // Redirects outrank stalls: a flushed pipeline has no hazard left to wait on.
   always_comb begin
      en_PC    = 1'b1;
      en_FD    = 1'b1;
      flush_FD = 1'b0;
      flush_DE = 1'b0;
      flush_EM = 1'b0;
      flush_MW = 1'b0;
      pc_sel   = PC_SEL_SEQ;
      if (reset) begin
         flush_FD = 1'b1;
         flush_DE = 1'b1;
         flush_EM = 1'b1;
         flush_MW = 1'b1;
      end else if (exc_M) begin
         pc_sel   = PC_SEL_EXC;
         flush_FD = 1'b1;
         flush_DE = 1'b1;
         flush_EM = 1'b1;
         flush_MW = 1'b1;
      end else if (eret_M) begin
         pc_sel   = PC_SEL_EPC;
         flush_FD = 1'b1;
         flush_DE = 1'b1;
         flush_EM = 1'b1;
      end else if (stall) begin
         en_PC    = 1'b0;
         en_FD    = 1'b0;
         flush_DE = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/redirect scenarios plus
// randomized traffic against a remaining-busy-cycles reference model.
module tb_pipe_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall_req_D, md_use_D, md_start_E, md_div_E, exc_M, eret_M;
   logic       en_PC, en_FD, flush_FD, flush_DE, flush_EM, flush_MW;
   logic [1:0] pc_sel;
   logic       md_go, md_busy;
   logic [9:0] obs;

   int n_checks = 0;
   int n_fail   = 0;
   int rem      = 0;

   pipe_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .stall_req_D(stall_req_D), .md_use_D(md_use_D),
      .md_start_E(md_start_E), .md_div_E(md_div_E), .exc_M(exc_M), .eret_M(eret_M),
      .en_PC(en_PC), .en_FD(en_FD), .flush_FD(flush_FD), .flush_DE(flush_DE),
      .flush_EM(flush_EM), .flush_MW(flush_MW), .pc_sel(pc_sel),
      .md_go(md_go), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   assign obs = {en_PC, en_FD, flush_FD, flush_DE, flush_EM, flush_MW, pc_sel, md_go, md_busy};

   // Expected {en_PC,en_FD,flush_FD,flush_DE,flush_EM,flush_MW,pc_sel,md_go,md_busy}
   function automatic logic [9:0] model_out();
      logic busy, go, stall;
      busy  = !reset && (rem > 0);
      go    = md_start_E && !exc_M && !eret_M && !reset;
      stall = stall_req_D || (md_use_D && (busy || md_start_E));
      if (reset)       return {2'b11, 4'b1111, 2'b00, 1'b0, busy};
      else if (exc_M)  return {2'b11, 4'b1111, 2'b01, go, busy};
      else if (eret_M) return {2'b11, 4'b1110, 2'b10, go, busy};
      else if (stall)  return {2'b00, 4'b0100, 2'b00, go, busy};
      else             return {2'b11, 4'b0000, 2'b00, go, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) rem = 0;
      else if (md_start_E && !exc_M && !eret_M) rem = md_div_E ? DIV_N : MULT_N;
      else if (rem > 0) rem--;
      #1;
   endtask

   task automatic idle_inputs();
      stall_req_D = 0; md_use_D = 0; md_start_E = 0; md_div_E = 0; exc_M = 0; eret_M = 0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < 20 && rem > 0; i++) tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         md_start_E = 1'($urandom_range(0, 1));
         md_use_D   = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++;
         if (obs !== 10'b11_1111_00_0_0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 10'b11_1111_00_0_0);
         end
         tick();
      end
      reset = 0;
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== 10'b11_0000_00_0_0) begin
         n_fail++;
         $display("[TB] FAIL after_reset: got %b expected %b", obs, 10'b11_0000_00_0_0);
      end
      tick();
   endtask

   task automatic test_mult();
      idle_inputs();
      md_start_E = 1;
      @(negedge clk);
      n_checks++;
      if (md_go !== 1'b1 || md_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mult_go: got go=%b busy=%b expected go=1 busy=0", md_go, md_busy);
      end
      tick();
      md_start_E = 0;
      for (int i = 0; i < MULT_N + 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (md_busy !== 1'(i < MULT_N) || md_go !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mult_busy cycle %0d: got busy=%b go=%b expected busy=%b go=0",
                     i, md_busy, md_go, i < MULT_N);
         end
         tick();
      end
   endtask

   task automatic test_div_stall();
      int stalled;
      idle_inputs();
      md_use_D = 1; md_start_E = 1; md_div_E = 1;
      stalled = 0;
      for (int i = 0; i < DIV_N + 1; i++) begin
         @(negedge clk);
         n_checks++;
         if (en_FD !== 1'b0 || en_PC !== 1'b0 || flush_DE !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL div_stall cycle %0d: got en_FD=%b en_PC=%b flush_DE=%b expected 0 0 1",
                     i, en_FD, en_PC, flush_DE);
         end else stalled++;
         tick();
         md_start_E = 0; md_div_E = 0;
      end
      @(negedge clk);
      n_checks++;
      if (obs !== 10'b11_0000_00_0_0 || stalled != DIV_N + 1) begin
         n_fail++;
         $display("[TB] FAIL div_resume: got %b after %0d stall cycles expected %b after %0d",
                  obs, stalled, 10'b11_0000_00_0_0, DIV_N + 1);
      end
      tick();
      drain();
   endtask

   task automatic test_redirect();
      logic [9:0] exp;
      idle_inputs();
      stall_req_D = 1; exc_M = 1;
      exp = 10'b11_1111_01_0_0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL exc_over_stall: got %b expected %b", obs, exp);
      end
      tick();
      idle_inputs();
      exc_M = 1; eret_M = 1;
      @(negedge clk);
      n_checks++;
      if (pc_sel !== 2'b01 || flush_MW !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL exc_over_eret: got pc_sel=%b flush_MW=%b expected 01 1", pc_sel, flush_MW);
      end
      tick();
      idle_inputs();
      eret_M = 1; stall_req_D = 1;
      exp = 10'b11_1110_10_0_0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL eret_alone: got %b expected %b", obs, exp);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_md_suppress();
      idle_inputs();
      md_start_E = 1; md_div_E = 1; exc_M = 1;
      @(negedge clk);
      n_checks++;
      if (md_go !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL suppress_go: got %b expected 0", md_go);
      end
      tick();
      exc_M = 0; eret_M = 1;
      @(negedge clk);
      n_checks++;
      if (md_go !== 1'b0 || md_busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL suppress_eret: got go=%b busy=%b expected 0 0", md_go, md_busy);
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (md_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL suppress_busy cycle %0d: got %b expected 0", i, md_busy);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      md_start_E = 1; md_div_E = 1;
      tick();
      idle_inputs();
      exc_M = 1;
      tick();
      eret_M = 1; exc_M = 0;
      tick();
      idle_inputs();
      md_start_E = 1;
      tick();
      idle_inputs();
      for (int i = 0; i < MULT_N + 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (md_busy !== 1'(i < MULT_N)) begin
            n_fail++;
            $display("[TB] FAIL restart_busy cycle %0d: got %b expected %b", i, md_busy, i < MULT_N);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_div();
      logic [9:0] exp;
      idle_inputs();
      md_start_E = 1; md_div_E = 1;
      tick();
      idle_inputs();
      for (int i = 0; i < 20 && rem != 3; i++) tick();
      reset = 1; md_start_E = 1;
      rem = 0;
      exp = 10'b11_1111_00_0_0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_div: got %b expected %b", obs, exp);
      end
      tick();
      reset = 0; md_start_E = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (md_busy !== 1'b0 || obs !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle cycle %0d: got %b expected %b", i, obs, model_out());
         end
         tick();
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         stall_req_D = ($urandom_range(0, 99) < 15);
         md_use_D    = ($urandom_range(0, 99) < 40);
         md_start_E  = ($urandom_range(0, 99) < 20);
         md_div_E    = 1'($urandom_range(0, 1));
         exc_M       = ($urandom_range(0, 99) < 8);
         eret_M      = ($urandom_range(0, 99) < 8);
         @(negedge clk);
         n_checks++;
         if (obs !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obs, model_out());
         end
         tick();
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_mult();
      test_div_stall();
      test_redirect();
      test_md_suppress();
      test_back_to_back();
      test_reset_mid_div();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
